// File: rtl/sdf_bf2_stage.sv
// ---------------------------------------------------------------------------
// sdf_bf2_stage
//
// Radix-2 single-path delay feedback (SDF) butterfly stage for an R2^2 SDF
// FFT pipeline. The feedback delay line of DEPTH samples lives outside this
// module. This stage owns the frame counter, the butterfly arithmetic, the
// input handshake and the output valid.
//
// A frame is 2*DEPTH samples:
//   - The first half is written into the delay line unchanged.
//   - The second half produces sums on the output and differences back into
//     the line.
// The stored differences come out while the next frame's first half loads.
// If no frame follows, they come out during a drain.
//
// Parameters
//   DEPTH : half-frame length / feedback delay (power of two, >= 1)
//   WIDTH : input sample width per component (signed)
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : input handshake (in_ready low only while draining)
//   in_re, in_im          : input sample, WIDTH bits signed
//   out_valid             : output sample valid (registered)
//   out_re, out_im        : output sample, WIDTH+1 bits signed (registered)
//   dly_in_re/im          : to delay line input (combinational)
//   dly_out_re/im         : from delay line output (latency DEPTH clocks)
//   err_gap               : sticky, in_valid dropped mid-frame
//
// Build option
//   SDF_BF_SCALE_EN : when defined, sum and difference are halved with
//                     round-half-up, (v+1)>>>1, before output and before
//                     storage. Ports are identical in both builds.
// ---------------------------------------------------------------------------
module sdf_bf2_stage #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_re,
    input  logic [WIDTH-1:0]   in_im,
    output logic               out_valid,
    output logic [WIDTH:0]     out_re,
    output logic [WIDTH:0]     out_im,
    output logic [WIDTH:0]     dly_in_re,
    output logic [WIDTH:0]     dly_in_im,
    input  logic [WIDTH:0]     dly_out_re,
    input  logic [WIDTH:0]     dly_out_im,
    output logic               err_gap
);

    localparam int CW  = $clog2(2 * DEPTH);
    localparam int DCW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0]  CNT_LAST  = CW'(2 * DEPTH - 1);
    localparam logic [CW-1:0]  CNT_HALF  = CW'(DEPTH);
    localparam logic [DCW-1:0] DCNT_LAST = DCW'(DEPTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state_reg;
    logic [CW-1:0]     cnt_reg;
    logic [DCW-1:0]    dcnt_reg;
    logic              primed_reg;
    logic              out_valid_reg;
    logic [WIDTH:0]    out_re_reg;
    logic [WIDTH:0]    out_im_reg;
    logic              err_gap_reg;

    logic              accept;
    logic              phase_b;
    logic [CW-1:0]     cnt_next;
    logic signed [WIDTH:0] in_ext_re, in_ext_im;
    logic signed [WIDTH:0] sum_re, sum_im, diff_re, diff_im;

    assign in_ready  = (state_reg != ST_DRAIN);
    assign accept    = in_valid & in_ready;
    // In IDLE cnt is held at 0, so an accepted sample there is phase A.
    assign phase_b   = (state_reg == ST_RUN) && (cnt_reg >= CNT_HALF);
    assign cnt_next  = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;

    assign in_ext_re = {in_re[WIDTH-1], in_re};
    assign in_ext_im = {in_im[WIDTH-1], in_im};

`ifdef SDF_BF_SCALE_EN
    // Work one bit wider so the +1 rounding cannot wrap. Dropping bit 0 is
    // the arithmetic shift right by one.
    localparam logic signed [WIDTH+1:0] ONE_W = {{(WIDTH+1){1'b0}}, 1'b1};
    logic signed [WIDTH+1:0] sum_w_re, sum_w_im, diff_w_re, diff_w_im;
    logic                    unused_lsb;

    assign sum_w_re  = {dly_out_re[WIDTH], dly_out_re} + {in_ext_re[WIDTH], in_ext_re} + ONE_W;
    assign sum_w_im  = {dly_out_im[WIDTH], dly_out_im} + {in_ext_im[WIDTH], in_ext_im} + ONE_W;
    assign diff_w_re = {dly_out_re[WIDTH], dly_out_re} - {in_ext_re[WIDTH], in_ext_re} + ONE_W;
    assign diff_w_im = {dly_out_im[WIDTH], dly_out_im} - {in_ext_im[WIDTH], in_ext_im} + ONE_W;
    assign sum_re    = sum_w_re[WIDTH+1:1];
    assign sum_im    = sum_w_im[WIDTH+1:1];
    assign diff_re   = diff_w_re[WIDTH+1:1];
    assign diff_im   = diff_w_im[WIDTH+1:1];
    assign unused_lsb = sum_w_re[0] ^ sum_w_im[0] ^ diff_w_re[0] ^ diff_w_im[0];
`else
    // In phase B, dly_out holds a first-half sample that is only WIDTH bits
    // wide, sign-extended. The sum and difference of two WIDTH-bit values
    // therefore fit in WIDTH+1 bits.
    assign sum_re    = $signed(dly_out_re) + in_ext_re;
    assign sum_im    = $signed(dly_out_im) + in_ext_im;
    assign diff_re   = $signed(dly_out_re) - in_ext_re;
    assign diff_im   = $signed(dly_out_im) - in_ext_im;
`endif

    // Delay-line feed. Anything that is not an accepted sample writes zero.
    always_comb begin
        dly_in_re = '0;
        dly_in_im = '0;
        if (accept) begin
            dly_in_re = phase_b ? diff_re : in_ext_re;
            dly_in_im = phase_b ? diff_im : in_ext_im;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            dcnt_reg      <= '0;
            primed_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            out_re_reg    <= '0;
            out_im_reg    <= '0;
            err_gap_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    primed_reg    <= 1'b0;
                    out_valid_reg <= 1'b0;
                    cnt_reg       <= '0;
                    if (accept) begin
                        out_re_reg <= dly_out_re;
                        out_im_reg <= dly_out_im;
                        cnt_reg    <= cnt_next;
                        state_reg  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        out_re_reg    <= phase_b ? sum_re : dly_out_re;
                        out_im_reg    <= phase_b ? sum_im : dly_out_im;
                        out_valid_reg <= phase_b | primed_reg;
                        cnt_reg       <= cnt_next;
                        if (cnt_reg == CNT_LAST) begin
                            primed_reg <= 1'b1;
                        end
                    end else if (cnt_reg != '0) begin
                        err_gap_reg   <= 1'b1;
                        out_valid_reg <= 1'b0;
                        primed_reg    <= 1'b0;
                        cnt_reg       <= '0;
                        state_reg     <= ST_IDLE;
                    end else begin
                        // The first stored difference is already at dly_out
                        // on the boundary cycle, so emit it now. The drain
                        // then covers the remaining DEPTH-1 differences.
                        out_re_reg    <= dly_out_re;
                        out_im_reg    <= dly_out_im;
                        out_valid_reg <= 1'b1;
                        dcnt_reg      <= '0;
                        state_reg     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    out_re_reg    <= dly_out_re;
                    out_im_reg    <= dly_out_im;
                    // On the last drain cycle dly_out carries the zero that
                    // was written on the boundary cycle, which is not data.
                    out_valid_reg <= (dcnt_reg != DCNT_LAST);
                    if (dcnt_reg == DCNT_LAST) begin
                        primed_reg <= 1'b0;
                        cnt_reg    <= '0;
                        state_reg  <= ST_IDLE;
                    end else begin
                        dcnt_reg <= dcnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_re    = out_re_reg;
    assign out_im    = out_im_reg;
    assign err_gap   = err_gap_reg;

endmodule
